// File: rtl/ctrl_packet_encoder_pkg.sv
// Shared control-packet types, field positions and the encode function.
// The decoder uses the same constants and encode_ctrl for its parity check.
package ctrl_packet_encoder_pkg;

  typedef enum logic [1:0] {
    OP_NOP     = 2'd0,
    OP_LOAD    = 2'd1,
    OP_STORE   = 2'd2,
    OP_COMPUTE = 2'd3
  } op_code_e;

  typedef enum logic [1:0] {
    COMP_ADD  = 2'd0,
    COMP_MUL  = 2'd1,
    COMP_MAX  = 2'd2,
    COMP_RELU = 2'd3
  } comp_type_e;

  typedef struct packed {
    logic [7:0] unit_id;
    op_code_e   op_code;
    comp_type_e comp_type;
    logic [3:0] addr;
    logic       valid;
    logic [2:0] size;
  } decoded_ctrl_t;

  typedef struct packed {
    logic [7:0] unit_id;
    logic [5:0] ctrl;
    logic [7:0] cfg;
  } ctrl_packet_t;

  localparam int unsigned CTRL_OP_LSB     = 4;
  localparam int unsigned CTRL_COMP_LSB   = 2;
  localparam int unsigned CTRL_VALID_BIT  = 1;
  localparam int unsigned CTRL_PARITY_BIT = 0;
  localparam int unsigned CFG_ADDR_LSB    = 4;
  localparam int unsigned CFG_SIZE_LSB    = 1;

  // Parity bit makes the whole 22-bit packet even parity.
  function automatic ctrl_packet_t encode_ctrl(input decoded_ctrl_t c);
    ctrl_packet_t p;
    p = '0;
    p.unit_id                      = c.unit_id;
    p.ctrl[CTRL_OP_LSB +: 2]       = c.op_code;
    p.ctrl[CTRL_COMP_LSB +: 2]     = c.comp_type;
    p.ctrl[CTRL_VALID_BIT]         = 1'b1;
    p.cfg[CFG_ADDR_LSB +: 4]       = c.addr;
    p.cfg[CFG_SIZE_LSB +: 3]       = c.size;
    p.ctrl[CTRL_PARITY_BIT]        = ^p;
    return p;
  endfunction

endpackage

// File: rtl/ctrl_packet_encoder_cmd_fifo.sv
// Synchronous command FIFO with flush; DEPTH must be a power of two >= 2.
module ctrl_packet_encoder_cmd_fifo #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ctrl_packet_encoder.sv
// Buffers decoded control commands, encodes them with parity and drives them
// onto the unit control bus; invalid (and optionally NOP) commands are dropped.
module ctrl_packet_encoder
  import ctrl_packet_encoder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter bit          DROP_NOP   = 1'b1,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  decoded_ctrl_t                 in_cmd,
  input  logic                          flush,
  output logic                          pkt_valid,
  input  logic                          pkt_ready,
  output ctrl_packet_t                  pkt_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          drop_count,
  output logic                          busy
);

  decoded_ctrl_t head;
  logic          fifo_empty;
  logic          fifo_full;
  logic          accept;
  logic          keep;
  logic          push;
  logic          drop;
  logic          load;

  // in_ready only sees registered state and flush, never pkt_ready.
  assign in_ready = !flush && !fifo_full;
  assign accept   = in_valid && in_ready;
  assign keep     = in_cmd.valid && !(DROP_NOP && (in_cmd.op_code == OP_NOP));
  assign push     = accept && keep;
  assign drop     = accept && !keep;
  assign load     = !fifo_empty && (!pkt_valid || pkt_ready);
  assign busy     = (fifo_count != '0) || pkt_valid;

  ctrl_packet_encoder_cmd_fifo #(
    .WIDTH ($bits(decoded_ctrl_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .push  (push),
    .pop   (load),
    .wdata (in_cmd),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  // Output register: holds while stalled, refills from the FIFO head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_valid <= 1'b0;
      pkt_out   <= '0;
    end else if (flush) begin
      pkt_valid <= 1'b0;
      pkt_out   <= '0;
    end else if (load) begin
      pkt_valid <= 1'b1;
      pkt_out   <= encode_ctrl(head);
    end else if (pkt_ready) begin
      pkt_valid <= 1'b0;
    end
  end

  // Saturating drop counter survives flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_count <= '0;
    end else if (drop && (drop_count != '1)) begin
      drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule
